// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: stage-control codes
// understood by the PC / IF-ID / ID-EX registers, opcodes that read rt,
// FSM state type and an rt-usage decode helper.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    CTL_LOAD  = 2'd0,
    CTL_HOLD  = 2'd1,
    CTL_FLUSH = 2'd2
  } ctl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Instructions that read rt as a source operand (R-type, branches, stores).
  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline and the hazard control unit.
//   slave  : hazard unit side (takes ID/EX status, drives control codes + counters)
//   master : pipeline / bench side
interface hazard_control_unit_if #(parameter int CNT_W = 32);
  logic [31:0]      ID_Instruction;
  logic             ID_Jump;
  logic [1:0]       EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             EX_BranchTaken;
  logic [1:0]       PC_Signal;
  logic [1:0]       IF_ID_Signal;
  logic [1:0]       ID_EX_Signal;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport slave (
    input  ID_Instruction, ID_Jump, EX_MemRead, EX_WriteReg, EX_BranchTaken,
    output PC_Signal, IF_ID_Signal, ID_EX_Signal, StallCount, FlushCount
  );

  modport master (
    output ID_Instruction, ID_Jump, EX_MemRead, EX_WriteReg, EX_BranchTaken,
    input  PC_Signal, IF_ID_Signal, ID_EX_Signal, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one event; holds at all-ones
//   cnt      : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit: produces hold/flush/load codes for PC, IF/ID and ID/EX
// from load-use and control hazards, and counts stall/flush cycles.
//   Clk, Rst : clock, synchronous active-high reset
//   hz       : pipeline status in, stage-control codes and perf counters out
// Control codes are combinational from state + current inputs so the
// pipeline registers act on them at the same edge.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hazard_control_unit_if.slave  hz
);
  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] stall_left_q, stall_left_d;
  ctl_e       pc_ctl, ifid_ctl, idex_ctl;
  logic       stall_inc, flush_inc, lu;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       unused_instr_bits;

  assign op = hz.ID_Instruction[31:26];
  assign rs = hz.ID_Instruction[25:21];
  assign rt = hz.ID_Instruction[20:16];
  assign unused_instr_bits = ^hz.ID_Instruction[15:0];

  // $zero as destination never carries a real dependency.
  assign lu = (hz.EX_MemRead != 2'd0) && (hz.EX_WriteReg != 5'd0) &&
              ((hz.EX_WriteReg == rs) || (uses_rt(op) && hz.EX_WriteReg == rt));

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    pc_ctl       = CTL_LOAD;
    ifid_ctl     = CTL_LOAD;
    idex_ctl     = CTL_LOAD;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (Rst) begin
      pc_ctl       = CTL_HOLD;
      ifid_ctl     = CTL_FLUSH;
      idex_ctl     = CTL_FLUSH;
      state_d      = ST_RUN;
      stall_left_d = 4'd0;
    end else if (hz.EX_BranchTaken) begin
      // Wrong-path fetch in IF/ID and ID is squashed; aborts any stall.
      ifid_ctl     = CTL_FLUSH;
      idex_ctl     = CTL_FLUSH;
      flush_inc    = 1'b1;
      state_d      = ST_RUN;
      stall_left_d = 4'd0;
    end else if (state_q == ST_STALL || lu) begin
      pc_ctl    = CTL_HOLD;
      ifid_ctl  = CTL_HOLD;
      idex_ctl  = CTL_FLUSH;
      stall_inc = 1'b1;
      if (state_q == ST_STALL) begin
        // LU is not re-checked here; RUN re-evaluates once the bubbles drain.
        stall_left_d = stall_left_q - 4'd1;
        if (stall_left_q == 4'd1) state_d = ST_RUN;
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_d      = ST_STALL;
        stall_left_d = STALL_RELOAD;
      end
    end else if (hz.ID_Jump) begin
      // Jump target is already fetched next; only the slot behind it dies.
      ifid_ctl  = CTL_FLUSH;
      flush_inc = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_RUN;
      stall_left_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
    end
  end

  assign hz.PC_Signal    = pc_ctl;
  assign hz.IF_ID_Signal = ifid_ctl;
  assign hz.ID_EX_Signal = idex_ctl;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (Clk), .rst (Rst), .clr (Rst), .inc (stall_inc), .cnt (hz.StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (Clk), .rst (Rst), .clr (Rst), .inc (flush_inc), .cnt (hz.FlushCount)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share one stimulus stream:
//   A: LOAD_STALL_CYCLES=1, CNT_W=4   B: LOAD_STALL_CYCLES=3, CNT_W=32
// A behavioural model (remaining-bubble count + integer counters) predicts
// the control codes and counters of both every cycle.
module tb_hazard_control_unit;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] instr;
  logic        jmp, br;
  logic [1:0]  memrd;
  logic [4:0]  wreg;

  always #5 Clk = ~Clk;

  hazard_control_unit_if #(.CNT_W(4))  if_a ();
  hazard_control_unit_if #(.CNT_W(32)) if_b ();

  assign if_a.ID_Instruction = instr;  assign if_b.ID_Instruction = instr;
  assign if_a.ID_Jump        = jmp;    assign if_b.ID_Jump        = jmp;
  assign if_a.EX_MemRead     = memrd;  assign if_b.EX_MemRead     = memrd;
  assign if_a.EX_WriteReg    = wreg;   assign if_b.EX_WriteReg    = wreg;
  assign if_a.EX_BranchTaken = br;     assign if_b.EX_BranchTaken = br;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  dut_a (.Clk(Clk), .Rst(Rst), .hz(if_a));
  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (.Clk(Clk), .Rst(Rst), .hz(if_b));

  int total = 0;
  int bad   = 0;

  // Model state per instance.
  int     lsc [2] = '{1, 3};
  longint mx  [2] = '{15, 64'hFFFF_FFFF};
  int     busy[2] = '{0, 0};
  longint sc  [2] = '{0, 0};
  longint fc  [2] = '{0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  function automatic bit load_use();
    bit reads_rt = 0;
    int rt_ops[6] = '{'h00, 'h04, 'h05, 'h28, 'h29, 'h2B};
    foreach (rt_ops[i]) if (int'(instr[31:26]) == rt_ops[i]) reads_rt = 1;
    if (memrd == 0 || wreg == 0) return 0;
    return (wreg == instr[25:21]) || (reads_rt && wreg == instr[20:16]);
  endfunction

  // Expected {PC, IF_ID, ID_EX} codes.
  function automatic logic [5:0] exp_ctl(input int k);
    if (Rst)                       return {2'd1, 2'd2, 2'd2};
    if (br)                        return {2'd0, 2'd2, 2'd2};
    if (busy[k] > 0 || load_use()) return {2'd1, 2'd1, 2'd2};
    if (jmp)                       return {2'd0, 2'd2, 2'd0};
    return 6'd0;
  endfunction

  task automatic model_step();
    bit lu = load_use();
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        busy[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (br) begin
        busy[k] = 0;
        if (fc[k] < mx[k]) fc[k]++;
      end else if (busy[k] > 0) begin
        busy[k]--;
        if (sc[k] < mx[k]) sc[k]++;
      end else if (lu) begin
        busy[k] = lsc[k] - 1;
        if (sc[k] < mx[k]) sc[k]++;
      end else if (jmp) begin
        if (fc[k] < mx[k]) fc[k]++;
      end
    end
  endtask

  // One clock: compare mid-cycle, then advance model with the edge.
  task automatic cycle();
    @(negedge Clk);
    chk("ctl_a", {58'd0, if_a.PC_Signal, if_a.IF_ID_Signal, if_a.ID_EX_Signal}, {58'd0, exp_ctl(0)});
    chk("ctl_b", {58'd0, if_b.PC_Signal, if_b.IF_ID_Signal, if_b.ID_EX_Signal}, {58'd0, exp_ctl(1)});
    chk("stall_a", {60'd0, if_a.StallCount}, sc[0]);
    chk("flush_a", {60'd0, if_a.FlushCount}, fc[0]);
    chk("stall_b", {32'd0, if_b.StallCount}, sc[1]);
    chk("flush_b", {32'd0, if_b.FlushCount}, fc[1]);
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    instr = 32'd0; jmp = 0; br = 0; memrd = 0; wreg = 0;
  endtask

  task automatic do_reset();
    idle(); Rst = 1; cycle(); cycle(); Rst = 0;
  endtask

  initial begin
    idle(); Rst = 1;
    @(posedge Clk); #1;

    // Reset and idle after release.
    do_reset();
    cycle();
    chk("t1_sc", {60'd0, if_a.StallCount}, 0);
    chk("t1_fc", {60'd0, if_a.FlushCount}, 0);

    // Load-use on rs, then same with $zero destination.
    do_reset();
    memrd = 1; wreg = 8; instr = mk(6'h00, 5'd8, 5'd10);
    cycle();
    idle(); cycle();
    chk("t2_sc", {60'd0, if_a.StallCount}, 1);
    do_reset();
    memrd = 1; wreg = 0; instr = mk(6'h00, 5'd0, 5'd10);
    cycle();
    chk("t2_zero", {60'd0, if_a.StallCount}, 0);

    // rt only matters for rt-reading opcodes.
    do_reset();
    memrd = 1; wreg = 8; instr = mk(6'h08, 5'd9, 5'd8);
    cycle();
    chk("t3_addi", {60'd0, if_a.StallCount}, 0);
    instr = mk(6'h2B, 5'd9, 5'd8);
    cycle();
    idle(); cycle();
    chk("t3_sw", {60'd0, if_a.StallCount}, 1);

    // Multi-cycle stall, then branch aborting the stall.
    do_reset();
    memrd = 2; wreg = 5; instr = mk(6'h00, 5'd3, 5'd5);
    cycle();
    idle(); cycle(); cycle(); cycle();
    chk("t4_sc3", {32'd0, if_b.StallCount}, 3);
    memrd = 2; wreg = 5; instr = mk(6'h00, 5'd5, 5'd3);
    cycle();
    idle(); br = 1; cycle();
    br = 0; cycle();
    chk("t4_sc4", {32'd0, if_b.StallCount}, 4);
    chk("t4_fc",  {32'd0, if_b.FlushCount}, 1);

    // Jump coinciding with load-use waits for the stall.
    do_reset();
    memrd = 1; wreg = 7; instr = mk(6'h00, 5'd7, 5'd0); jmp = 1;
    cycle();
    memrd = 0; wreg = 0;
    cycle();
    jmp = 0; cycle();
    chk("t5_fc", {60'd0, if_a.FlushCount}, 1);

    // Saturation of the 4-bit flush counter.
    do_reset();
    br = 1;
    for (int i = 0; i < 20; i++) cycle();
    br = 0; cycle();
    chk("t6_sat", {60'd0, if_a.FlushCount}, 15);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [5:0] ops[8] = '{6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B, 6'h08, 6'h23};
      logic [4:0] regs[4] = '{5'd0, 5'd8, 5'd9, 5'd10};
      Rst   = ($urandom_range(0, 49) == 0);
      br    = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 5) == 0);
      memrd = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      wreg  = regs[$urandom_range(0, 3)];
      instr = mk(ops[$urandom_range(0, 7)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer of the 2-bit stage-control codes consumed by the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use data hazards and control hazards: taken branch resolved in EX, and jump decoded in ID.
- Issues hold / flush / load commands to each register.
- Counts stall and flush cycles for performance debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15); values above 1 cover slow data memory.
CNT_W, 32, width of the saturating performance counters.

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous, active-high reset
ID_Instruction  in  32  instruction held in IF/ID (opcode [31:26], rs [25:21], rt [20:16])
ID_Jump  in  1  j/jal/jr decoded in ID
EX_MemRead  in  2  EX-stage load type; nonzero = load
EX_WriteReg  in  5  destination register of the EX-stage instruction
EX_BranchTaken  in  1  branch in EX resolved taken this cycle
PC_Signal  out  2  0 = load next PC, 1 = hold
IF_ID_Signal  out  2  0 = load, 1 = hold, 2 = flush
ID_EX_Signal  out  2  0 = load, 1 = hold, 2 = flush (bubble)
StallCount  out  CNT_W  cycles spent stalling for load-use
FlushCount  out  CNT_W  cycles in which a control flush was issued

Behaviour:
- Code encoding is shared with the pipeline registers. Code 3 is never driven.
- Control outputs are combinational from registered state plus current inputs. The registers sample them at the same rising edge, so there is zero added latency.
- FSM states: RUN, STALL. A 4-bit down-counter StallLeft is valid in STALL.
- Load-use hazard (LU) is true when all of the following hold:
  - EX_MemRead != 0
  - EX_WriteReg != 0
  - EX_WriteReg == rs, OR (UsesRt AND EX_WriteReg == rt)
- UsesRt = opcode 0x00 (R-type), 0x04, 0x05, 0x28, 0x29 or 0x2B.
- Priority each cycle: Rst > EX_BranchTaken > (LU or STALL) > ID_Jump > normal.
- Rst high:
  - PC_Signal = 1, IF_ID_Signal = 2, ID_EX_Signal = 2.
  - Next state RUN, StallLeft = 0, both counters cleared to 0.
  - Reset mid-stall aborts the stall.
- EX_BranchTaken:
  - PC = 0, IF_ID = 2, ID_EX = 2.
  - Next state RUN, StallLeft cleared.
  - FlushCount += 1. StallCount is unchanged even if LU is also true.
- RUN with LU:
  - PC = 1, IF_ID = 1, ID_EX = 2.
  - StallCount += 1.
  - If LOAD_STALL_CYCLES > 1: next state STALL, StallLeft = LOAD_STALL_CYCLES - 1. Otherwise remain in RUN.
- STALL:
  - Same outputs as LU, StallCount += 1, StallLeft -= 1.
  - When StallLeft == 1 at the edge, next state RUN.
  - LU is not re-evaluated in STALL. It is re-checked in RUN, so a new dependency raised there gets a fresh stall.
- ID_Jump with no higher-priority event:
  - PC = 0, IF_ID = 2, ID_EX = 0.
  - FlushCount += 1.
  - A jump that coincides with LU waits; it is taken once the stall ends.
- Normal: all outputs 0.
- Counters saturate at all-ones and never wrap.
- Register 0 is never a hazard source.

Decomposition:
- Shared package holds:
  - stage-control enum: CTL_LOAD = 0, CTL_HOLD = 1, CTL_FLUSH = 2
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW
  - FSM state typedef
- One natural sub-module: sat_counter (parameterised width; clear and increment inputs), instantiated twice.

Test Plan:
1. Reset and counter initialisation:
   - Stimulus: Rst = 1 for 2 cycles, then release with all inputs idle.
   - Required: during reset, outputs = (1, 2, 2). After release, outputs = (0, 0, 0), StallCount = 0, FlushCount = 0.
2. Load-use stall and register-0 exclusion:
   - Stimulus: EX_MemRead = 1, EX_WriteReg = 8, ID_Instruction = add $t1,$t0,$t2 (rs = 8), LOAD_STALL_CYCLES = 1.
   - Required: exactly one cycle of (1, 1, 2). StallCount goes 0 -> 1. Repeating the stimulus with EX_WriteReg = 0 produces no stall.
3. rt-use filtering:
   - Stimulus: addi with rt = 8 against a load to register 8.
   - Required: no stall. sw with rt = 8 against the same load stalls one cycle.
4. Multi-cycle stall with branch abort:
   - Stimulus: LOAD_STALL_CYCLES = 3 with an LU event.
   - Required: 3 consecutive stall cycles, StallCount = 3.
   - Stimulus: repeat the LU, then assert EX_BranchTaken in the 2nd stall cycle.
   - Required: that cycle outputs (0, 2, 2), next cycle (0, 0, 0), StallCount += 1 only, FlushCount += 1.
5. Jump deferred by load-use:
   - Stimulus: ID_Jump = 1 coinciding with LU.
   - Required: first cycle (1, 1, 2), next cycle (0, 2, 0), FlushCount = 1.
6. Counter saturation:
   - Stimulus: CNT_W = 4, then 20 consecutive branch-taken cycles.
   - Required: FlushCount stops at 15.
